commit_queue: RTL

Parametrised in-order commit stage that buffers up to DEPTH executed instructions between execute and architectural state. It replaces the single-entry commit register with a ready/valid queue. Each cycle it retires the head entry as a register writeback, a data-FIFO store, a jump redirect, or an exception. It adds a trap-vector redirect and a retired-instruction counter.

---
 rtl/commit_pkg.sv | 30 +++
 rtl/commit_fifo.sv | 60 ++++++
 rtl/commit_queue.sv | 133 +++++++++++++
 3 files changed

// File: rtl/commit_pkg.sv
// Shared types for the in-order commit stage: per-entry payload and head retire state.
// Entry widths follow the package defaults; commit_queue parameters default to them.
package commit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int EXC_W_DEF = 6;

  typedef enum logic [1:0] {
    NODATA,
    COMMIT,
    EXCEPTION,
    WAIT_FIFO
  } commit_state_e;

  typedef struct packed {
    logic [4:0]           rd;
    logic [XLEN_DEF-1:0]  rd_val;
    logic [XLEN_DEF-1:0]  inst_pc;
    logic [XLEN_DEF-1:0]  jump_pc;
    logic                 jump_valid;
    logic [EXC_W_DEF-1:0] exc_num;
    logic [XLEN_DEF-1:0]  exc_val;
    logic                 exc_valid;
    logic [XLEN_DEF-1:0]  store_addr;
    logic [XLEN_DEF-1:0]  store_val;
    logic [1:0]           store_size;
    logic                 store_valid;
  } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// Circular DEPTH-entry buffer with push/pop/flush; write visible at head one cycle later.
// No internal backpressure: the caller must only push below DEPTH and only pop when non-empty.
module commit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [W-1:0]               head_dat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + AW'(1);
      if (pop_i)  head_d = head_q + AW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_dat_i;
  end

  assign count_o    = count_q;
  assign head_dat_o = mem_q[head_q];

endmodule

// File: rtl/commit_queue.sv
// In-order commit queue: retires head as writeback/store/jump/exception, min 1-cycle latency.
// execute_ready is registered-only (count < DEPTH); a full data FIFO stalls the head store.
module commit_queue
  import commit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter int EXC_W = EXC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             execute_valid,
  output logic             execute_ready,
  input  logic [4:0]       execute_rd,
  input  logic [XLEN-1:0]  execute_rd_val,
  input  logic [XLEN-1:0]  execute_inst_pc,
  input  logic [XLEN-1:0]  execute_jump_pc,
  input  logic             execute_jump_valid,
  input  logic [EXC_W-1:0] execute_exception_num,
  input  logic [XLEN-1:0]  execute_exception_val,
  input  logic             execute_exception_valid,
  input  logic [XLEN-1:0]  execute_store_addr,
  input  logic [XLEN-1:0]  execute_store_val,
  input  logic [1:0]       execute_store_size,
  input  logic             execute_store_valid,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             datafifo_full,
  output logic [XLEN-1:0]  datafifo_addr_out,
  output logic [XLEN-1:0]  datafifo_val_out,
  output logic [1:0]       datafifo_size_out,
  output logic             datafifo_valid_out,
  output logic [EXC_W-1:0] exception_num_out,
  output logic [XLEN-1:0]  exception_val_out,
  output logic [XLEN-1:0]  exception_pc_out,
  output logic             exception_valid_out,
  output logic [4:0]       rd_out,
  output logic [XLEN-1:0]  rd_val_out,
  output logic             rd_valid_out,
  output logic             commit_valid,
  output logic             pipeline_flush,
  output logic [XLEN-1:0]  pipeline_pc,
  output logic [63:0]      commit_count
);

  localparam int CW = $clog2(DEPTH + 1);

  commit_entry_t in_ent, head;
  commit_state_e state;
  logic [CW-1:0] count;
  logic          push;
  logic [63:0]   cnt_q, cnt_d;

  always_comb begin
    in_ent             = '0;
    in_ent.rd          = execute_rd;
    in_ent.rd_val      = execute_rd_val;
    in_ent.inst_pc     = execute_inst_pc;
    in_ent.jump_pc     = execute_jump_pc;
    in_ent.jump_valid  = execute_jump_valid;
    in_ent.exc_num     = execute_exception_num;
    in_ent.exc_val     = execute_exception_val;
    in_ent.exc_valid   = execute_exception_valid;
    in_ent.store_addr  = execute_store_addr;
    in_ent.store_val   = execute_store_val;
    in_ent.store_size  = execute_store_size;
    in_ent.store_valid = execute_store_valid;
  end

  assign execute_ready = reset && (count < CW'(DEPTH));
  assign push          = execute_valid && execute_ready && !pipeline_flush;

  commit_fifo #(
    .W     ($bits(commit_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .push_i     (push),
    .push_dat_i (in_ent),
    .pop_i      (commit_valid),
    .flush_i    (pipeline_flush),
    .count_o    (count),
    .head_dat_o (head)
  );

  // Gating with reset keeps every output at 0 during the reset cycle itself.
  always_comb begin
    state = NODATA;
    if (reset && count != '0) begin
      if (head.exc_valid)                           state = EXCEPTION;
      else if (head.store_valid && datafifo_full)   state = WAIT_FIFO;
      else                                          state = COMMIT;
    end
  end

  always_comb begin
    datafifo_addr_out   = '0;
    datafifo_val_out    = '0;
    datafifo_size_out   = '0;
    exception_num_out   = '0;
    exception_val_out   = '0;
    exception_pc_out    = '0;
    rd_out              = '0;
    rd_val_out          = '0;
    pipeline_pc         = '0;
    rd_valid_out        = (state == COMMIT) && (head.rd != 5'd0);
    datafifo_valid_out  = (state == COMMIT) && head.store_valid;
    exception_valid_out = (state == EXCEPTION);
    commit_valid        = (state == COMMIT) || (state == EXCEPTION);
    pipeline_flush      = (state == EXCEPTION) || ((state == COMMIT) && head.jump_valid);
    if (state != NODATA) begin
      datafifo_addr_out = head.store_addr;
      datafifo_val_out  = head.store_val;
      datafifo_size_out = head.store_size;
      exception_num_out = head.exc_num;
      exception_val_out = head.exc_val;
      exception_pc_out  = head.inst_pc;
      rd_out            = head.rd;
      rd_val_out        = head.rd_val;
      pipeline_pc       = (state == EXCEPTION) ? trap_vector : head.jump_pc;
    end
  end

  assign cnt_d = commit_valid ? cnt_q + 64'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign commit_count = reset ? cnt_q : 64'd0;

endmodule
